// File: rtl/apb_timer_if.sv
// ----------------------------------------------------------------------------
// apb_timer_if
//   Bus bundle between the UART-to-APB bridge (master) and the APB timer
//   (slave). There is no psel on this bus: a transfer is active whenever
//   penable is high.
//
//   paddr   master->slave  32  byte address, [3:2] selects a register
//   penable master->slave   1  access phase
//   pwrite  master->slave   1  1 = write, 0 = read
//   pwdata  master->slave  32  write data
//   prdata  slave->master  32  read data
//   pready  slave->master   1  transfer completes on an edge with penable & pready
// ----------------------------------------------------------------------------
interface apb_timer_if;
   logic [31:0] paddr;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;

   modport master (
      output paddr, penable, pwrite, pwdata,
      input  prdata, pready
   );

   modport slave (
      input  paddr, penable, pwrite, pwdata,
      output prdata, pready
   );
endinterface

// File: rtl/apb_timer.sv
// ----------------------------------------------------------------------------
// apb_timer
//   32-bit down-counting timer on the bridge's APB-style bus, with a level
//   interrupt. A 16-bit prescaler divides clk by PRESCALE; each prescaler wrap
//   is one counter tick.
//
//   Register map (paddr[3:2]):
//     0x0 CTRL   RW  bit0 enable, bit1 auto_reload, bit2 irq_en
//     0x4 LOAD   RW  reload value
//     0x8 COUNT  RO  current counter value
//     0xC STATUS W1C bit0 expired
//
//   Parameters:
//     BASE      block responds when paddr[31:4] == BASE[31:4]
//     PRESCALE  clk cycles per counter tick, 1..65535
//
//   Ports:
//     clk    in   system clock, rising edge
//     reset  in   synchronous active-high reset
//     bus    slave modport of apb_timer_if (paddr/penable/pwrite/pwdata in,
//            prdata/pready out)
//     irq    out  registered STATUS.expired & CTRL.irq_en
//
//   Build option:
//     APB_TIMER_WAIT_EN  when defined, every transfer takes one wait state and
//                        prdata/pready are registered; otherwise pready is
//                        tied high and prdata is combinational.
// ----------------------------------------------------------------------------
module apb_timer #(
   parameter logic [31:0] BASE     = 32'h0000_0000,
   parameter logic [15:0] PRESCALE = 16'd10
) (
   input  logic       clk,
   input  logic       reset,
   apb_timer_if.slave bus,
   output logic       irq
);

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_LOAD   = 2'd1,
      REG_COUNT  = 2'd2,
      REG_STATUS = 2'd3
   } reg_sel_e;

   localparam logic [15:0] PRESC_LAST = PRESCALE - 16'd1;

   logic [2:0]  ctrl_q,    ctrl_d;
   logic [31:0] load_q,    load_d;
   logic [31:0] count_q,   count_d;
   logic [15:0] presc_q,   presc_d;
   logic        expired_q, expired_d;
   logic        irq_q;

   logic        hit;
   reg_sel_e    sel;
   logic        wr_hit;
   logic        wr_ctrl;
   logic        tick;
   logic        run;
   logic        set_exp;
   logic [31:0] rdata;
   logic        unused_paddr;

   assign hit          = (bus.paddr[31:4] == BASE[31:4]);
   assign sel          = reg_sel_e'(bus.paddr[3:2]);
   assign unused_paddr = ^bus.paddr[1:0];

   // Misses complete like hits but never commit.
   assign wr_hit  = bus.penable & bus.pwrite & bus.pready & hit;
   assign wr_ctrl = wr_hit & (sel == REG_CTRL);

   // ------------------------------------------------------------------------
   // Read mux (registers as they stand before the current edge)
   // ------------------------------------------------------------------------
   always_comb begin
      rdata = '0;
      if (hit) begin
         case (sel)
            REG_CTRL:   rdata = {29'd0, ctrl_q};
            REG_LOAD:   rdata = load_q;
            REG_COUNT:  rdata = count_q;
            REG_STATUS: rdata = {31'd0, expired_q};
            default:    rdata = '0;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Bus response
   // ------------------------------------------------------------------------
`ifdef APB_TIMER_WAIT_EN
   logic        pready_q;
   logic [31:0] prdata_q;

   // pready goes high in the second penable cycle and drops right after the
   // completing edge, so back-to-back transfers each take two cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         pready_q <= 1'b0;
         prdata_q <= '0;
      end else begin
         pready_q <= bus.penable & ~pready_q;
         if (bus.penable & ~pready_q) begin
            prdata_q <= rdata;
         end
      end
   end

   assign bus.pready = pready_q;
   assign bus.prdata = prdata_q;
`else
   assign bus.pready = 1'b1;
   assign bus.prdata = rdata;
`endif

   // ------------------------------------------------------------------------
   // Timer next state
   // ------------------------------------------------------------------------
   assign tick = ctrl_q[0] & (presc_q == PRESC_LAST);

   // A CTRL write that clears enable overrides this edge's counting entirely,
   // including a coincident tick.
   assign run = ctrl_q[0] & ~(wr_ctrl & ~bus.pwdata[0]);

   always_comb begin
      ctrl_d    = ctrl_q;
      load_d    = load_q;
      count_d   = count_q;
      presc_d   = presc_q;
      expired_d = expired_q;
      set_exp   = 1'b0;

      if (run) begin
         presc_d = tick ? 16'd0 : presc_q + 16'd1;
         if (tick) begin
            if (count_q != 32'd0) begin
               count_d = count_q - 32'd1;
            end else begin
               set_exp = 1'b1;
               if (ctrl_q[1]) begin
                  count_d = load_q;
               end else begin
                  ctrl_d[0] = 1'b0;
               end
            end
         end
      end

      if (wr_hit) begin
         case (sel)
            REG_CTRL: begin
               // Written enable overrides a same-edge auto-disable.
               ctrl_d = bus.pwdata[2:0];
               if (~ctrl_q[0] & bus.pwdata[0]) begin
                  count_d = load_q;
                  presc_d = 16'd0;
               end
            end
            REG_LOAD: load_d = bus.pwdata;
            REG_STATUS: begin
               if (bus.pwdata[0]) begin
                  expired_d = 1'b0;
               end
            end
            default: ;
         endcase
      end

      // Expiry beats a simultaneous W1C.
      if (set_exp) begin
         expired_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q    <= '0;
         load_q    <= '0;
         count_q   <= '0;
         presc_q   <= '0;
         expired_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         load_q    <= load_d;
         count_q   <= count_d;
         presc_q   <= presc_d;
         expired_q <= expired_d;
         // irq trails expired by one clk.
         irq_q     <= expired_q & ctrl_q[2];
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_apb_timer.sv
module tb_apb_timer;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          PRESC = 10;
`ifdef APB_TIMER_WAIT_EN
   localparam int   LAT        = 2;
   localparam logic PREADY_RST = 1'b0;
`else
   localparam int   LAT        = 1;
   localparam logic PREADY_RST = 1'b1;
`endif

   logic clk = 1'b0;
   logic rst;
   logic irq;
   int   cyc = 0;
   int   chk_cnt = 0;
   int   pass_cnt = 0;

   apb_timer_if bus ();

   apb_timer #(.BASE(BASE), .PRESCALE(16'(PRESC))) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus),
      .irq   (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   // Committed transfer, announced by the bus task before the committing edge.
   logic        c_vld = 1'b0;
   logic        c_wr;
   logic [31:0] c_addr;
   logic [31:0] c_data;

   logic [2:0]  m_ctrl;
   logic [31:0] m_load, m_count;
   logic        m_exp, m_irq;
   int          m_wait;   // edges remaining until next tick while enabled

   always @(posedge clk) begin : model
      logic [2:0]  n_ctrl;
      logic [31:0] n_load, n_count;
      logic        n_exp, set_e, whit, running;
      int          n_wait;
      if (rst) begin
         m_ctrl = 0; m_load = 0; m_count = 0; m_exp = 0; m_irq = 0; m_wait = PRESC;
      end else begin
         n_ctrl = m_ctrl; n_load = m_load; n_count = m_count; n_exp = m_exp; n_wait = m_wait;
         set_e  = 1'b0;
         whit   = c_vld && c_wr && (c_addr[31:4] == BASE[31:4]);
         running = m_ctrl[0] && !(whit && c_addr[3:2] == 2'd0 && !c_data[0]);
         if (running) begin
            if (m_wait == 1) begin
               n_wait = PRESC;
               if (m_count > 0) n_count = m_count - 1;
               else begin
                  set_e = 1'b1;
                  if (m_ctrl[1]) n_count = m_load;
                  else n_ctrl[0] = 1'b0;
               end
            end else n_wait = m_wait - 1;
         end
         if (whit) begin
            case (c_addr[3:2])
               2'd0: begin
                  n_ctrl = c_data[2:0];
                  if (!m_ctrl[0] && c_data[0]) begin n_count = m_load; n_wait = PRESC; end
               end
               2'd1: n_load = c_data;
               2'd3: if (c_data[0]) n_exp = 1'b0;
               default: ;
            endcase
         end
         if (set_e) n_exp = 1'b1;
         m_irq = m_exp && m_ctrl[2];
         m_ctrl = n_ctrl; m_load = n_load; m_count = n_count; m_exp = n_exp; m_wait = n_wait;
      end
   end

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a[31:4] != BASE[31:4]) return 32'd0;
      case (a[3:2])
         2'd0:    return {29'd0, m_ctrl};
         2'd1:    return m_load;
         2'd2:    return m_count;
         default: return {31'd0, m_exp};
      endcase
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Starts #1 after a rising edge, ends #1 after the completing edge.
   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] rd, output logic [31:0] snap,
                       output logic ok, output int waits);
      bus.paddr = a; bus.pwrite = w; bus.pwdata = d; bus.penable = 1'b1;
      @(negedge clk);
      snap  = model_read(a);
      waits = 0;
      while (!bus.pready && waits < 4) begin
         @(negedge clk);
         waits++;
      end
      ok = bus.pready;
      rd = bus.prdata;
      if (ok) begin
         c_addr = a; c_wr = w; c_data = d; c_vld = 1'b1;
      end
      @(posedge clk);
      #1;
      c_vld = 1'b0;
      bus.penable = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] rd, sn; logic ok; int wt;
      xfer(a, 1'b1, d, rd, sn, ok, wt);
      check("write_done", {31'd0, ok}, 32'd1);
   endtask

   task automatic rd_const(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] rd, sn; logic ok; int wt;
      xfer(a, 1'b0, 32'd0, rd, sn, ok, wt);
      check(name, rd, exp);
   endtask

   task automatic rd_model(input string name, input logic [31:0] a);
      logic [31:0] rd, sn; logic ok; int wt;
      xfer(a, 1'b0, 32'd0, rd, sn, ok, wt);
      check(name, rd, sn);
      check("irq_vs_model", {31'd0, irq}, {31'd0, m_irq});
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[17];

   initial begin
      logic [31:0] rd, sn;
      logic        ok;
      int          wt, n, t1, t2;

      bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_irq", {31'd0, irq}, 32'd0);
      check("reset_pready", {31'd0, bus.pready}, {31'd0, PREADY_RST});
      check("reset_prdata", bus.prdata, 32'd0);
      @(posedge clk); #1;

      // ---- register access table (timer disabled) ----
      vt[0]  = '{32'h0,   1'b0, 32'h0,         32'h0};
      vt[1]  = '{32'h4,   1'b0, 32'h0,         32'h0};
      vt[2]  = '{32'h8,   1'b0, 32'h0,         32'h0};
      vt[3]  = '{32'hC,   1'b0, 32'h0,         32'h0};
      vt[4]  = '{32'h4,   1'b1, 32'h1234_5678, 32'h0};
      vt[5]  = '{32'h4,   1'b0, 32'h0,         32'h1234_5678};
      vt[6]  = '{32'h0,   1'b1, 32'hFFFF_FFF6, 32'h0};
      vt[7]  = '{32'h0,   1'b0, 32'h0,         32'h6};
      vt[8]  = '{32'h8,   1'b1, 32'hDEAD_BEEF, 32'h0};
      vt[9]  = '{32'h8,   1'b0, 32'h0,         32'h0};
      vt[10] = '{32'h104, 1'b1, 32'hAAAA_AAAA, 32'h0};
      vt[11] = '{32'h104, 1'b0, 32'h0,         32'h0};
      vt[12] = '{32'h4,   1'b0, 32'h0,         32'h1234_5678};
      vt[13] = '{32'h100, 1'b1, 32'h5,         32'h0};
      vt[14] = '{32'h0,   1'b0, 32'h0,         32'h6};
      vt[15] = '{32'h102, 1'b0, 32'h0,         32'h0};
      vt[16] = '{32'h0,   1'b1, 32'h0,         32'h0};
      for (int i = 0; i < 17; i++) begin
         xfer(vt[i].addr, vt[i].wr, vt[i].data, rd, sn, ok, wt);
         check($sformatf("vec%0d_done", i), {31'd0, ok}, 32'd1);
         check($sformatf("vec%0d_waits", i), wt, LAT - 1);
         if (!vt[i].wr) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
      end

      // ---- one-shot countdown: LOAD=3, enable ----
      wr(32'h4, 32'd3);
      wr(32'h0, 32'h1);
      rd_const("cnt_3", 32'h8, 32'd3);
      idle(12);
      rd_const("cnt_2", 32'h8, 32'd2);
      idle(10);
      rd_const("cnt_1", 32'h8, 32'd1);
      idle(10);
      rd_const("cnt_0", 32'h8, 32'd0);
      idle(10);
      rd_const("oneshot_expired", 32'hC, 32'd1);
      rd_const("oneshot_ctrl", 32'h0, 32'd0);
      rd_const("oneshot_hold", 32'h8, 32'd0);
      wr(32'hC, 32'h0);
      rd_const("w0_no_clear", 32'hC, 32'd1);
      wr(32'hC, 32'h1);
      rd_const("w1c_clear", 32'hC, 32'd0);

      // ---- auto-reload LOAD=1 with irq: expiry every 20 clks ----
      wr(32'h4, 32'd1);
      wr(32'h0, 32'h7);
      n = 0;
      @(negedge clk);
      while (!irq && n < 100) begin @(negedge clk); n++; end
      check("irq_rise1", {31'd0, irq}, 32'd1);
      t1 = cyc;
      @(posedge clk); #1;
      rd_const("reload_count", 32'h8, 32'd1);
      wr(32'hC, 32'h1);
      n = 0;
      @(negedge clk);
      while (irq && n < 10) begin @(negedge clk); n++; end
      check("irq_fall", {31'd0, irq}, 32'd0);
      n = 0;
      while (!irq && n < 100) begin @(negedge clk); n++; end
      check("irq_rise2", {31'd0, irq}, 32'd1);
      t2 = cyc;
      check("irq_period", t2 - t1, 32'd20);
      @(posedge clk); #1;
      rd_model("reload_model", 32'h8);

      // ---- W1C on the exact expiry edge (LOAD=0, every tick expires) ----
      wr(32'h4, 32'd0);
      n = 0;
      while (!(m_exp && m_count == 0 && m_ctrl[0] && m_wait == LAT) && n < 100) begin
         idle(1);
         n++;
      end
      check("race_align", {31'd0, (n < 100)}, 32'd1);
      wr(32'hC, 32'h1);
      @(negedge clk);
      check("race_irq_high", {31'd0, irq}, 32'd1);
      @(posedge clk); #1;
      rd_const("race_expired", 32'hC, 32'd1);
      check("race_irq_still", {31'd0, irq}, 32'd1);

      // ---- reset in the middle of a transfer while counting from 5 ----
      wr(32'h4, 32'd5);
      wr(32'h0, 32'h4);
      wr(32'h0, 32'h5);
      rd_const("pre_reset_count", 32'h8, 32'd5);
      bus.paddr = 32'h4; bus.pwrite = 1'b1; bus.pwdata = 32'h99; bus.penable = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.penable = 1'b0;
      @(negedge clk);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_pready", {31'd0, bus.pready}, {31'd0, PREADY_RST});
      @(posedge clk); #1;
      rd_const("rst_ctrl", 32'h0, 32'd0);
      rd_const("rst_load", 32'h4, 32'd0);
      rd_const("rst_count", 32'h8, 32'd0);
      rd_const("rst_status", 32'hC, 32'd0);
      wr(32'h4, 32'd7);
      rd_const("post_rst_load", 32'h4, 32'd7);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 300; i++) begin
         logic [31:0] ra;
         int op;
         op = $urandom_range(0, 11);
         ra = {28'd0, 2'($urandom_range(0, 3)), 2'b00};
         case (op)
            0, 1: wr(32'h4, 32'($urandom_range(0, 4)));
            2:    wr(32'h0, 32'($urandom_range(0, 7)));
            3:    wr(32'hC, 32'($urandom_range(0, 1)));
            4:    wr(32'h8, $urandom);
            5:    wr(32'h100 | ra, $urandom);
            6:    rd_model("rand_miss", 32'h100 | ra);
            7, 8, 9: rd_model("rand_read", ra);
            default: idle($urandom_range(1, 25));
         endcase
      end
      rd_model("final_count", 32'h8);
      rd_model("final_status", 32'hC);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
      $fatal(1);
   end

endmodule
